// File: rtl/conv_stream_pkg.sv
// Shared widths, FSM state encoding and the pixel packing helper for conv_stream_packer.
// Combinational definitions only; no latency or backpressure of its own.
package conv_stream_pkg;

    localparam int NB_PIXEL_PKG = 8;
    localparam int NB_DATA_PKG  = 4 * NB_PIXEL_PKG;

    typedef enum logic [1:0] {
        S_SKIP  = 2'd0,
        S_PASS  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                   last;
        logic [NB_DATA_PKG-1:0] dat;
    } out_word_t;

    // Window 0 lands in the least significant byte.
    function automatic logic [NB_DATA_PKG-1:0] pack4(
        input logic [NB_PIXEL_PKG-1:0] p3,
        input logic [NB_PIXEL_PKG-1:0] p2,
        input logic [NB_PIXEL_PKG-1:0] p1,
        input logic [NB_PIXEL_PKG-1:0] p0
    );
        return {p3, p2, p1, p0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; a push is visible at dout one cycle later when empty.
// Pushes while full and pops while empty are ignored; full/empty come from registered pointers.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The extra pointer bit separates a wrapped (full) FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/conv_stream_packer.sv
// Packs four conv results per group into AXI-Stream words, dropping line-buffer fill and tagging tlast.
// One cycle group-to-tvalid when buffer empty; o_ready follows registered FIFO full, groups offered while not ready are dropped.
module conv_stream_packer
    import conv_stream_pkg::*;
#(
    parameter int NB_PIXEL   = NB_PIXEL_PKG,
    parameter int NB_DATA    = NB_DATA_PKG,
    parameter int SKIP_WORDS = 400,
    parameter int OUT_WORDS  = 9800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_PIXEL-1:0] i_conv0,
    input  logic [NB_PIXEL-1:0] i_conv1,
    input  logic [NB_PIXEL-1:0] i_conv2,
    input  logic [NB_PIXEL-1:0] i_conv3,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [NB_DATA-1:0]  o_tdata,
    output logic                o_tvalid,
    output logic                o_tlast,
    input  logic                i_tready,
    output logic                o_frame_done,
    output logic                o_overflow
);

    localparam int SKIP_W = (SKIP_WORDS > 0) ? $clog2(SKIP_WORDS + 1) : 1;
    localparam int OUT_W  = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam state_t S_FRAME_START = (SKIP_WORDS == 0) ? S_PASS : S_SKIP;

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic              overflow_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              last_push;
    logic              tlast_hs;
    out_word_t         push_word;
    out_word_t         head_word;

    always_comb begin
        o_ready = 1'b0;
        case (state)
            S_SKIP:  o_ready = 1'b1;
            S_PASS:  o_ready = ~fifo_full;
            default: o_ready = 1'b0;
        endcase
    end

    assign accept    = i_valid & o_ready;
    assign push      = accept & (state == S_PASS);
    assign last_push = (out_cnt == OUT_W'(OUT_WORDS - 1));
    assign push_word = '{last: last_push, dat: pack4(i_conv3, i_conv2, i_conv1, i_conv0)};
    assign pop       = o_tvalid & i_tready;
    assign tlast_hs  = pop & head_word.last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_FRAME_START;
            skip_cnt   <= '0;
            out_cnt    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (i_valid && !o_ready) begin
                overflow_q <= 1'b1;
            end
            case (state)
                S_SKIP: begin
                    if (accept) begin
                        if (skip_cnt == SKIP_W'(SKIP_WORDS - 1)) begin
                            skip_cnt <= '0;
                            state    <= S_PASS;
                        end else begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end
                S_PASS: begin
                    if (push) begin
                        if (last_push) begin
                            out_cnt <= '0;
                            state   <= S_DRAIN;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tlast_hs) begin
                        state <= S_FRAME_START;
                    end
                end
                default: state <= S_FRAME_START;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (NB_DATA + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (push),
        .pop     (pop),
        .din     (push_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (head_word)
    );

    assign o_tvalid     = ~fifo_empty;
    assign o_tdata      = head_word.dat;
    assign o_tlast      = head_word.last;
    assign o_frame_done = tlast_hs & (state == S_DRAIN);
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_conv_stream_packer.sv
// Bench: two packers (3- and 8-word frames) share stimulus; a queue model checks every cycle,
// directed literal checks pin the expected words, drop points and sticky overflow.
module tb_conv_stream_packer;

    localparam int SKIP  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] c0, c1, c2, c3;
    logic       vld;
    logic       tready;

    logic        rdy [2];
    logic        tv  [2];
    logic        tl  [2];
    logic        fd  [2];
    logic        ov  [2];
    logic [31:0] td  [2];

    always #5 clk = ~clk;

    conv_stream_packer #(.NB_PIXEL(8), .NB_DATA(32), .SKIP_WORDS(SKIP), .OUT_WORDS(3), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_conv0(c0), .i_conv1(c1), .i_conv2(c2), .i_conv3(c3),
        .i_valid(vld), .o_ready(rdy[0]), .o_tdata(td[0]), .o_tvalid(tv[0]), .o_tlast(tl[0]),
        .i_tready(tready), .o_frame_done(fd[0]), .o_overflow(ov[0])
    );

    conv_stream_packer #(.NB_PIXEL(8), .NB_DATA(32), .SKIP_WORDS(SKIP), .OUT_WORDS(8), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_conv0(c0), .i_conv1(c1), .i_conv2(c2), .i_conv3(c3),
        .i_valid(vld), .o_ready(rdy[1]), .o_tdata(td[1]), .o_tvalid(tv[1]), .o_tlast(tl[1]),
        .i_tready(tready), .o_frame_done(fd[1]), .o_overflow(ov[1])
    );

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per instance, words still to skip, position in frame, drain flag and a word queue.
    logic [32:0] mbuf [2][64];
    int          mhead [2];
    int          mcount [2];
    int          skip_left [2];
    int          out_idx [2];
    bit          drain [2];
    bit          m_ovf [2];
    bit          armed = 1'b0;
    logic [31:0] lg [2][64];
    int          lgn [2] = '{0, 0};
    int          dones [2] = '{0, 0};

    logic        e_rdy, e_tv, e_fd, acc;
    logic [32:0] head;
    int          ow;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ow    = (k == 0) ? 3 : 8;
            e_rdy = drain[k] ? 1'b0 : (skip_left[k] > 0) ? 1'b1 : (mcount[k] < DEPTH);
            e_tv  = (mcount[k] > 0);
            head  = mbuf[k][mhead[k]];
            e_fd  = e_tv & tready & head[32];
            if (armed) begin
                chk($sformatf("ready%0d", k), {31'd0, rdy[k]}, {31'd0, e_rdy});
                chk($sformatf("tvalid%0d", k), {31'd0, tv[k]}, {31'd0, e_tv});
                chk($sformatf("frame_done%0d", k), {31'd0, fd[k]}, {31'd0, e_fd});
                chk($sformatf("overflow%0d", k), {31'd0, ov[k]}, {31'd0, m_ovf[k]});
                if (e_tv) begin
                    chk($sformatf("tdata%0d", k), td[k], head[31:0]);
                    chk($sformatf("tlast%0d", k), {31'd0, tl[k]}, {31'd0, head[32]});
                end
                if (tv[k] && tready) begin
                    lg[k][lgn[k] % 64] = td[k];
                    lgn[k]++;
                end
                if (fd[k]) dones[k]++;
            end
            if (rst) begin
                mhead[k] = 0; mcount[k] = 0; skip_left[k] = SKIP;
                out_idx[k] = 0; drain[k] = 1'b0; m_ovf[k] = 1'b0;
            end else begin
                acc = vld & e_rdy;
                if (vld && !e_rdy) m_ovf[k] = 1'b1;
                if (e_tv && tready) begin
                    mhead[k] = (mhead[k] + 1) % 64;
                    mcount[k]--;
                    if (head[32]) begin
                        drain[k] = 1'b0;
                        skip_left[k] = SKIP;
                    end
                end
                if (acc) begin
                    if (skip_left[k] > 0) begin
                        skip_left[k]--;
                    end else begin
                        mbuf[k][(mhead[k] + mcount[k]) % 64] = {(out_idx[k] == ow - 1), c3, c2, c1, c0};
                        mcount[k]++;
                        out_idx[k]++;
                        if (out_idx[k] == ow) begin
                            out_idx[k] = 0;
                            drain[k] = 1'b1;
                        end
                    end
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic send(input int n);
        c0 = 8'(n); c1 = 8'(n + 1); c2 = 8'(n + 2); c3 = 8'(n + 3);
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    int b0, b1, d0, d1;

    initial begin
        rst = 1'b1; vld = 1'b0; tready = 1'b0;
        c0 = 8'd0; c1 = 8'd0; c2 = 8'd0; c3 = 8'd0;

        // Reset state
        do_reset();
        chk("rst_tvalid", {31'd0, tv[0]}, 32'd0);
        chk("rst_tlast", {31'd0, tl[0]}, 32'd0);
        chk("rst_tdata", td[0], 32'd0);
        chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("rst_overflow", {31'd0, ov[0]}, 32'd0);

        // Basic frame with simultaneous push/pop: the head is always the latest word
        tready = 1'b1;
        b0 = lgn[0]; d0 = dones[0];
        send(0); send(4);
        chk("skip_no_tvalid", {31'd0, tv[0]}, 32'd0);
        send(8);  chk("pp_head0", td[0], 32'h0B0A0908);
        send(12); chk("pp_head1", td[0], 32'h0F0E0D0C);
        send(16); chk("pp_head2", td[0], 32'h13121110);
        chk("pp_tlast", {31'd0, tl[0]}, 32'd1);
        chk("pp_frame_done", {31'd0, fd[0]}, 32'd1);
        idle(4);
        chk("basic_count", lgn[0] - b0, 32'd3);
        chk("basic_w0", lg[0][b0], 32'h0B0A0908);
        chk("basic_w1", lg[0][b0 + 1], 32'h0F0E0D0C);
        chk("basic_w2", lg[0][b0 + 2], 32'h13121110);
        chk("basic_done", dones[0] - d0, 32'd1);
        chk("basic_no_ovf", {31'd0, ov[0]}, 32'd0);

        // Second frame without reset
        b1 = lgn[1]; d1 = dones[1];
        send(20); send(24); send(28); send(32); send(36);
        idle(4);
        chk("f2_count", lgn[0] - b0, 32'd6);
        chk("f2_w0", lg[0][b0 + 3], 32'h1F1E1D1C);
        chk("f2_w2", lg[0][b0 + 5], 32'h27262524);
        chk("f2_done_total", dones[0] - d0, 32'd2);
        chk("b_frame_words", lgn[1], 32'd8);
        chk("b_frame_done", dones[1], 32'd1);

        // Backpressure into drain
        do_reset();
        tready = 1'b0;
        b0 = lgn[0]; d0 = dones[0];
        send(0); send(4); send(8); send(12);
        chk("bp_ready_2push", {31'd0, rdy[0]}, 32'd1);
        send(16);
        chk("bp_ready_drain", {31'd0, rdy[0]}, 32'd0);
        chk("bp_hold0", td[0], 32'h0B0A0908);
        idle(3);
        chk("bp_hold1", td[0], 32'h0B0A0908);
        chk("bp_tvalid", {31'd0, tv[0]}, 32'd1);
        tready = 1'b1;
        idle(5);
        chk("bp_count", lgn[0] - b0, 32'd3);
        chk("bp_w0", lg[0][b0], 32'h0B0A0908);
        chk("bp_w2", lg[0][b0 + 2], 32'h13121110);
        chk("bp_done", dones[0] - d0, 32'd1);

        // Overflow on the 8-word instance
        do_reset();
        tready = 1'b0;
        b1 = lgn[1];
        for (int i = 0; i < 8; i++) begin
            send(4 * i);
            if (i == 4) chk("ovf_ready_3push", {31'd0, rdy[1]}, 32'd1);
            if (i == 5) chk("ovf_ready_full", {31'd0, rdy[1]}, 32'd0);
        end
        chk("ovf_set", {31'd0, ov[1]}, 32'd1);
        tready = 1'b1;
        idle(6);
        chk("ovf_sticky", {31'd0, ov[1]}, 32'd1);
        chk("ovf_ready_back", {31'd0, rdy[1]}, 32'd1);
        chk("ovf_count", lgn[1] - b1, 32'd4);
        chk("ovf_w0", lg[1][b1], 32'h0B0A0908);
        chk("ovf_w3", lg[1][b1 + 3], 32'h17161514);

        // Reset mid-PASS
        do_reset();
        tready = 1'b0;
        b0 = lgn[0];
        send(0); send(4); send(8);
        chk("mid_buffered", {31'd0, tv[0]}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_tvalid", {31'd0, tv[0]}, 32'd0);
        chk("mid_overflow", {31'd0, ov[0]}, 32'd0);
        chk("mid_ready", {31'd0, rdy[0]}, 32'd1);
        tready = 1'b1;
        send(40); send(44);
        idle(3);
        chk("mid_skipped", {31'd0, tv[0]}, 32'd0);
        chk("mid_no_words", lgn[0] - b0, 32'd0);
        tready = 1'b0;
        send(48);
        chk("mid_first_word", td[0], 32'h33323130);
        chk("mid_first_tvalid", {31'd0, tv[0]}, 32'd1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
